// File: rtl/arity_vector_checker_pkg.sv
// Shared types and width helpers for the arity vector checker and its lookup table.
package arity_vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Settle counter width covers SETTLE values 1..15.
    localparam int unsigned CNT_W = 4;

    function automatic int unsigned num_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    function automatic int unsigned table_bits(input int unsigned n_in, input int unsigned n_out);
        return n_out * num_vec(n_in);
    endfunction

endpackage

// File: rtl/arity_vector_lut.sv
// Expected-response lookup: returns the truth-table entry for one input vector.
module arity_vector_lut
    import arity_vector_checker_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 3,
    parameter logic [table_bits(N_IN, N_OUT)-1:0] EXP_TABLE = 24'h000FAC
) (
    input  logic [N_IN-1:0]  vec,
    output logic [N_OUT-1:0] expected
);

    localparam int unsigned NUM_VEC = num_vec(N_IN);

    logic [N_OUT-1:0] entries [NUM_VEC];

    for (genvar g = 0; g < NUM_VEC; g++) begin : g_entry
        assign entries[g] = EXP_TABLE[g*N_OUT +: N_OUT];
    end

    assign expected = entries[vec];

endmodule

// File: rtl/arity_vector_checker.sv
// Exhaustive stimulus/response checker: walks every input vector of a combinational
// circuit, samples its output after SETTLE cycles and records the verdict.
module arity_vector_checker
    import arity_vector_checker_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_OUT  = 3,
    parameter int unsigned SETTLE = 1,
    parameter logic [table_bits(N_IN, N_OUT)-1:0] EXP_TABLE = 24'h000FAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_on_fail,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic [N_OUT-1:0] first_fail_obs
);

    localparam logic [N_IN:0]      VEC_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0]      LAST_VEC = {1'b0, {N_IN{1'b1}}};
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t             state, state_next;
    logic [N_IN:0]      vec;
    logic [N_IN:0]      vec_inc;
    logic [CNT_W-1:0]   cnt;
    logic               stop_flag;
    logic [N_OUT-1:0]   expected;
    logic               mismatch;
    logic               sample;
    logic               finish;

    arity_vector_lut #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .EXP_TABLE (EXP_TABLE)
    ) u_lut (
        .vec      (vec[N_IN-1:0]),
        .expected (expected)
    );

    assign mismatch = (dut_out != expected);
    assign vec_inc  = vec + VEC_ONE;
    assign pass     = done & (err_count == '0);

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = APPLY;
            end
            APPLY: begin
                if (cnt == '0) begin
                    sample = 1'b1;
                    if ((vec == LAST_VEC) || (mismatch && stop_flag)) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec            <= '0;
            cnt            <= '0;
            stop_flag      <= 1'b0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_obs <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        first_fail_obs <= '0;
                        done           <= 1'b0;
                        stop_flag      <= stop_on_fail;
                        vec            <= '0;
                        dut_in         <= '0;
                        cnt            <= CNT_LOAD;
                        busy           <= 1'b1;
                    end
                end
                APPLY: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Only the final settle cycle of each vector is compared.
                        if (mismatch) begin
                            if (err_count == '0) begin
                                first_fail_vec <= vec[N_IN-1:0];
                                first_fail_obs <= dut_out;
                            end
                            err_count <= err_count + VEC_ONE;
                        end
                        if (finish) begin
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            dut_in <= '0;
                        end else begin
                            vec    <= vec_inc;
                            dut_in <= vec_inc[N_IN-1:0];
                            cnt    <= CNT_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arity_vector_checker.sv
// Bench for arity_vector_checker: two checker instances (SETTLE=1 and SETTLE=3) each
// driving a behavioural model of the arity-1/2/3 circuit with injectable faults.
module tb_arity_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, stop1, start3, stop3;
    logic       stuck1, glitch3;
    logic [2:0] dut_in1, dut_out1, dut_in3, dut_out3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [3:0] err1, err3;
    logic [2:0] ffv1, ffo1, ffv3, ffo3;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [2:0] v, input logic stuck, input logic glitch);
        logic [2:0] r;
        r = (v < 3'd4) ? (v + 3'd4) : 3'd0;
        if (stuck)  r[1] = 1'b0;
        if (glitch) r = ~r;
        return r;
    endfunction

    assign dut_out1 = model(dut_in1, stuck1, 1'b0);
    assign dut_out3 = model(dut_in3, 1'b0, glitch3);

    arity_vector_checker #(
        .N_IN(3), .N_OUT(3), .SETTLE(1), .EXP_TABLE(24'h000FAC)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop_on_fail(stop1),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_obs(ffo1)
    );

    arity_vector_checker #(
        .N_IN(3), .N_OUT(3), .SETTLE(3), .EXP_TABLE(24'h000FAC)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stop_on_fail(stop3),
        .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail_vec(ffv3), .first_fail_obs(ffo3)
    );

    typedef struct {
        string      name;
        logic       sel;      // 0: SETTLE=1 instance, 1: SETTLE=3 instance
        logic       stuck;
        logic       stop;
        logic       glitch;
        logic       poke;     // extra start pulse while busy
        int         busy_len;
        logic [3:0] err;
        logic [2:0] ffv;
        logic [2:0] ffo;
        logic       pass;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cur_busy(input logic sel);
        return sel ? 32'(busy3) : 32'(busy1);
    endfunction

    function automatic logic [31:0] cur_in(input logic sel);
        return sel ? 32'(dut_in3) : 32'(dut_in1);
    endfunction

    task automatic run_case(input vec_t r);
        int c;
        int settle;
        settle = r.sel ? 3 : 1;
        stuck1 = r.stuck;
        if (r.sel) stop3 = r.stop; else stop1 = r.stop;
        for (int i = 0; i < r.busy_len; i++) exp_q.push_back(i / settle);
        @(negedge clk);
        if (r.sel) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        c = 0;
        while (cur_busy(r.sel) == 1 && c < 100) begin
            glitch3 = r.glitch && (c % 3 != 2);
            start1  = r.poke && !r.sel && (c == 3);
            start3  = r.poke &&  r.sel && (c == 3);
            if (exp_q.size() > 0) check({r.name, ".dut_in"}, cur_in(r.sel), 32'(exp_q.pop_front()));
            c++;
            @(negedge clk);
        end
        glitch3 = 1'b0;
        start1  = 1'b0;
        start3  = 1'b0;
        exp_q.delete();
        check({r.name, ".busy_cycles"}, c, r.busy_len);
        if (r.sel) begin
            check({r.name, ".done"}, done3, 1);
            check({r.name, ".pass"}, pass3, r.pass);
            check({r.name, ".err_count"}, err3, r.err);
            check({r.name, ".first_fail_vec"}, ffv3, r.ffv);
            check({r.name, ".first_fail_obs"}, ffo3, r.ffo);
            check({r.name, ".dut_in_idle"}, dut_in3, 0);
        end else begin
            check({r.name, ".done"}, done1, 1);
            check({r.name, ".pass"}, pass1, r.pass);
            check({r.name, ".err_count"}, err1, r.err);
            check({r.name, ".first_fail_vec"}, ffv1, r.ffv);
            check({r.name, ".first_fail_obs"}, ffo1, r.ffo);
            check({r.name, ".dut_in_idle"}, dut_in1, 0);
        end
    endtask

    initial begin
        int k;
        tbl[0] = '{"clean",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  8, 4'd0, 3'd0, 3'b000, 1'b1};
        tbl[1] = '{"stuck_full", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  8, 4'd2, 3'd2, 3'b100, 1'b0};
        tbl[2] = '{"stuck_stop", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  3, 4'd1, 3'd2, 3'b100, 1'b0};
        tbl[3] = '{"settle3",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 4'd0, 3'd0, 3'b000, 1'b1};
        tbl[4] = '{"poke_busy",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  8, 4'd0, 3'd0, 3'b000, 1'b1};
        tbl[5] = '{"fail_again", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  8, 4'd2, 3'd2, 3'b100, 1'b0};

        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; stop1 = 1'b0; stop3 = 1'b0;
        stuck1 = 1'b0; glitch3 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.outputs1", {busy1, done1, pass1, err1, ffv1, ffo1, dut_in1}, 0);
        check("reset.outputs3", {busy3, done3, pass3, err3, ffv3, ffo3, dut_in3}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_case(tbl[i]);

        // Restart from DONE after the failing run: results clear on the accepting edge.
        stuck1 = 1'b0;
        stop1  = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        check("restart.cleared", {done1, pass1, err1, ffv1, ffo1}, 0);
        check("restart.busy", busy1, 1);
        k = 0;
        while (!done1 && k < 50) begin @(negedge clk); k++; end
        check("restart.done", done1, 1);
        check("restart.pass", pass1, 1);
        check("restart.err_count", err1, 0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0;
        while (dut_in1 != 3'd5 && k < 50) begin @(negedge clk); k++; end
        check("midrst.reached_v5", dut_in1, 5);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.outputs", {busy1, done1, pass1, err1, ffv1, ffo1}, 0);
        check("midrst.dut_in", dut_in1, 0);
        @(negedge clk); rst_n = 1'b1;
        run_case(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
